apb_mem_slave: RTL and testbench

- Parametrised APB4 completer with a byte-addressable register memory.
- Generalises the write-only fixed-wait slave to reads and writes, with:
  - configurable address width, data width and depth;
  - a configurable number of wait states;
  - PSTRB byte-lane writes;
  - PSLVERR error response.
- Sits behind the APB bridge as the generic memory-mapped target for block-level benches and SoC scratch space.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_byte_mem.sv | 35 +++
 rtl/apb_mem_slave.sv | 101 ++++++++++
 tb/tb_apb_mem_slave.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, widths and byte-strobe merge for the APB memory completer
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int WAIT_W     = 4;
    localparam int MAX_DATA_W = 64;
    localparam int MAX_NB     = MAX_DATA_W / 8;

    // Operates at the widest supported bus; callers zero-extend in and truncate out.
    function automatic logic [MAX_DATA_W-1:0] merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] wdata,
        input logic [MAX_NB-1:0]     strb
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < MAX_NB; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_byte_mem.sv
// rtl/apb_byte_mem.sv - DEPTH x DATA_W word store with byte-lane writes and async read
module apb_byte_mem
    import apb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int NB     = DATA_W / 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [NB-1:0]     strb_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= DATA_W'(merge(MAX_DATA_W'(mem_q[idx_i]),
                                          MAX_DATA_W'(wdata_i),
                                          MAX_NB'(strb_i)));
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/apb_mem_slave.sv
// rtl/apb_mem_slave.sv - APB4 completer: wait-state FSM, error decode, byte-addressable memory
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int                NB        = DATA_W / 8;
    localparam int                OFS       = $clog2(NB);
    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [63:0]       MEM_BYTES = 64'(DEPTH) * 64'(NB);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(NB - 1);

    apb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;

    logic              misaligned;
    logic              out_of_range;
    logic              err;
    logic [IDX_W-1:0]  idx;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    // Mask test instead of a PADDR[OFS-1:0] slice keeps DATA_W=8 (no lane bits) legal.
    assign misaligned   = |(PADDR & LANE_MASK);
    assign out_of_range = 64'(PADDR) >= MEM_BYTES;
    assign err          = misaligned | out_of_range;
    assign idx          = PADDR[OFS +: IDX_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (PSEL) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_W'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Completion is only ever qualified by registered state, so IDLE never responds.
    assign PREADY  = (state_q == ACCESS) & PSEL & PENABLE & (cnt_q == '0);
    assign PSLVERR = PREADY & err;
    assign mem_we  = PREADY & PWRITE & ~err;
    assign PRDATA  = (PREADY & ~PWRITE & ~err) ? mem_rdata : '0;

    apb_byte_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NB     (NB),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .we_i    (mem_we),
        .idx_i   (idx),
        .wdata_i (PWDATA),
        .strb_i  (PSTRB),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb/tb_apb_mem_slave.sv - directed vector bench for apb_mem_slave at WAIT_STATES 0 and 2
module tb_apb_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(2)) dut1 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    typedef struct {
        int          d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb, input bit last,
                        output logic [31:0] rd, output logic err, output int cycles);
        int n;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wd;
        pstrb[d]   = strb;
        cycles     = 1;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        cycles++;
        #1;
        n = 0;
        while (pready[d] !== 1'b1 && n < 40) begin
            @(posedge clk); #2;
            cycles++;
            n++;
        end
        if (n >= 40) begin
            n_bad++;
            $display("FAIL pready_timeout: dut%0d addr %h never completed", d, addr);
        end
        rd  = prdata[d];
        err = pslverr[d];
        @(posedge clk); #1;
        penable[d] = 1'b0;
        if (last) psel[d] = 1'b0;
    endtask

    task automatic read_expect(input int d, input logic [31:0] addr, input logic [31:0] exp,
                               input string name);
        logic [31:0] rd;
        logic        e;
        int          c;
        xfer(d, 1'b0, addr, 32'h0, 4'h0, 1'b1, rd, e, c);
        check(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          c;
        int          c0;

        vecs.push_back('{1, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 4});
        vecs.push_back('{1, 1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 4});
        vecs.push_back('{1, 1'b1, 32'h020, 32'h11223344, 4'hF, 32'h0,        1'b0, 4});
        vecs.push_back('{1, 1'b1, 32'h020, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 4});
        vecs.push_back('{1, 1'b0, 32'h020, 32'h0,        4'hF, 32'h11BB33DD, 1'b0, 4});
        vecs.push_back('{1, 1'b1, 32'h402, 32'h99999999, 4'hF, 32'h0,        1'b1, 4});
        vecs.push_back('{1, 1'b1, 32'h400, 32'h99999999, 4'hF, 32'h0,        1'b1, 4});
        vecs.push_back('{1, 1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1, 4});
        vecs.push_back('{1, 1'b0, 32'h000, 32'h0,        4'h0, 32'h0,        1'b0, 4});
        vecs.push_back('{1, 1'b1, 32'h012, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 4});
        vecs.push_back('{1, 1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 4});
        vecs.push_back('{1, 1'b1, 32'h3FC, 32'h5A5A5A5A, 4'hF, 32'h0,        1'b0, 4});
        vecs.push_back('{1, 1'b0, 32'h3FC, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0, 4});
        vecs.push_back('{1, 1'b1, 32'h024, 32'h77777777, 4'h0, 32'h0,        1'b0, 4});
        vecs.push_back('{1, 1'b0, 32'h024, 32'h0,        4'h0, 32'h0,        1'b0, 4});
        vecs.push_back('{1, 1'b0, 32'h011, 32'h0,        4'h0, 32'h0,        1'b1, 4});
        vecs.push_back('{0, 1'b1, 32'h004, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 2});
        vecs.push_back('{0, 1'b0, 32'h004, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 2});
        vecs.push_back('{0, 1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1, 2});

        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b1; penable[d] = 1'b1; pwrite[d] = 1'b0;
            paddr[d] = 32'h10; pwdata[d] = '0; pstrb[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_pready%0d", d), 32'(pready[d]), 32'h0);
            check($sformatf("reset_pslverr%0d", d), 32'(pslverr[d]), 32'h0);
            check($sformatf("reset_prdata%0d", d), prdata[d], 32'h0);
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 1'b1, rd, e, c);
            check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_pslverr", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_cycles", i), 32'(c), 32'(vecs[i].exp_cyc));
            @(posedge clk); #1;
        end

        // Back-to-back on the zero-wait instance: two transfers in exactly four cycles.
        c0 = cyc;
        xfer(0, 1'b1, 32'h008, 32'h12345678, 4'hF, 1'b0, rd, e, c);
        check("b2b_wr_cycles", 32'(c), 32'd2);
        xfer(0, 1'b0, 32'h008, 32'h0, 4'h0, 1'b1, rd, e, c);
        check("b2b_rd_data", rd, 32'h12345678);
        check("b2b_total_cycles", 32'(cyc - c0), 32'd4);
        @(posedge clk); #1;

        // Abort: PSEL dropped in the middle of the wait states.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h030; pwdata[1] = 32'hDEADBEEF; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        #1;
        check("abort_pready_wait", 32'(pready[1]), 32'h0);
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("abort_pready_idle%0d", k), 32'(pready[1]), 32'h0);
            @(posedge clk); #1;
        end
        xfer(1, 1'b0, 32'h030, 32'h0, 4'h0, 1'b1, rd, e, c);
        check("abort_no_write", rd, 32'h0);
        check("abort_next_cycles", 32'(c), 32'd4);
        @(posedge clk); #1;

        // Reset pulsed while a write is in its wait states.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h034; pwdata[1] = 32'h13579BDF; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_pready", 32'(pready[1]), 32'h0);
        @(posedge clk); #1;
        check("rst_held_pready", 32'(pready[1]), 32'h0);
        rst = 1'b0;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        read_expect(1, 32'h034, 32'h0, "rst_lost_write");
        read_expect(1, 32'h010, 32'h0, "rst_clear_10");
        read_expect(1, 32'h020, 32'h0, "rst_clear_20");
        read_expect(1, 32'h3FC, 32'h0, "rst_clear_3fc");
        read_expect(0, 32'h004, 32'h0, "rst_clear_dut0_4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
